// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and FSM encoding for the arithmetic unit
package arith_pkg;

    localparam int ARITH_WIDTH = 32;
    localparam int ARITH_CNT_W = $clog2(ARITH_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } arith_state_t;

endpackage

// File: rtl/partial_product_calculator.sv
// rtl/partial_product_calculator.sv - one shift-add step of the reconstruct multiplier
module partial_product_calculator
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mplier_bit,
    input  logic [CNT_W-1:0]   count,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [2*WIDTH-1:0] w_mcand_wide;
    logic [2*WIDTH-1:0] w_addend;

    assign w_mcand_wide = {{WIDTH{1'b0}}, mcand};
    assign w_addend     = mplier_bit ? (w_mcand_wide << count) : '0;
    assign acc_out      = acc_in + w_addend;

endmodule

// File: rtl/unsigned_multiply_reconstruct.sv
// rtl/unsigned_multiply_reconstruct.sv - rebuilds N = Q*D + R, one multiplier bit per cycle
module unsigned_multiply_reconstruct
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               VALID,
    input  logic [WIDTH-1:0]   Q,
    input  logic [WIDTH-1:0]   D,
    input  logic [WIDTH-1:0]   R,
    output logic [2*WIDTH-1:0] N,
    output logic               READY,
    output logic               BUSY,
    output logic               range_err
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    arith_state_t       r_state;
    arith_state_t       w_next_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_n;
    logic               r_range_err;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic               w_range_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (VALID) w_next_state = RUN;
            RUN:     if (r_count == LAST_CNT) w_next_state = DONE;
            DONE:    if (VALID) w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // VALID is only honoured outside RUN, so a running operation can't be disturbed.
    always_comb begin
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_last   = 1'b0;
        BUSY     = 1'b0;
        READY    = 1'b0;
        case (r_state)
            IDLE: w_accept = VALID;
            RUN: begin
                w_step = 1'b1;
                w_last = (r_count == LAST_CNT);
                BUSY   = 1'b1;
            end
            DONE: begin
                w_accept = VALID;
                READY    = 1'b1;
            end
            default: ;
        endcase
    end

    // D = R = 0 is a consistent remainder even though R >= D holds trivially.
    assign w_range_err = (R >= D) && ((D != '0) || (R != '0));

    partial_product_calculator #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ppc (
        .acc_in     (r_acc),
        .mcand      (r_mcand),
        .mplier_bit (r_mplier[0]),
        .count      (r_count),
        .acc_out    (w_acc_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_n         <= '0;
            r_range_err <= 1'b0;
        end else if (w_accept) begin
            r_mcand     <= D;
            r_mplier    <= Q;
            r_acc       <= {{WIDTH{1'b0}}, R};
            r_count     <= '0;
            r_n         <= '0;
            r_range_err <= w_range_err;
        end else if (w_step) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
            if (w_last) begin
                r_n <= w_acc_next;
            end
        end
    end

    assign N         = r_n;
    assign range_err = r_range_err;

endmodule

// File: tb/tb_unsigned_multiply_reconstruct.sv
// tb/tb_unsigned_multiply_reconstruct.sv - directed self-checking bench for the reconstruct multiplier
module tb_unsigned_multiply_reconstruct;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           VALID = 1'b0;
    logic [W-1:0]   Q = '0;
    logic [W-1:0]   D = '0;
    logic [W-1:0]   R = '0;
    logic [2*W-1:0] N;
    logic           READY;
    logic           BUSY;
    logic           range_err;

    int n_tests = 0;
    int n_fail  = 0;

    unsigned_multiply_reconstruct #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .VALID     (VALID),
        .Q         (Q),
        .D         (D),
        .R         (R),
        .N         (N),
        .READY     (READY),
        .BUSY      (BUSY),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until READY rises, starting from cycles already spent.
    task automatic wait_ready(input int start, output int cycles);
        cycles = start;
        while (!READY && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] q, input logic [W-1:0] d,
                          input logic [W-1:0] r, input logic [63:0] exp_n, input logic exp_err);
        int cyc;
        Q = q; D = d; R = r; VALID = 1'b1;
        tick();
        VALID = 1'b0;
        check({tag, "_busy_after_accept"}, 64'(BUSY), 64'd1);
        check({tag, "_ready_after_accept"}, 64'(READY), 64'd0);
        wait_ready(0, cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd32);
        check({tag, "_n"}, N, exp_n);
        check({tag, "_range_err"}, 64'(range_err), 64'(exp_err));
        check({tag, "_busy_done"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        int cyc;
        tick();
        tick();
        check("reset_n", N, 64'd0);
        check("reset_ready", 64'(READY), 64'd0);
        check("reset_busy", 64'(BUSY), 64'd0);
        check("reset_err", 64'(range_err), 64'd0);
        reset = 1'b1;
        tick();

        run_op("basic", 32'd7, 32'd5, 32'd3, 64'd38, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("done_hold_n", N, 64'd38);
        check("done_hold_ready", 64'(READY), 64'd1);

        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'hFFFF_FFFE_FFFF_FFFF, 1'b0);
        run_op("d_zero", 32'd5, 32'd0, 32'd3, 64'd3, 1'b1);
        run_op("r_eq_d", 32'd0, 32'd9, 32'd9, 64'd9, 1'b1);
        run_op("d_r_zero", 32'd5, 32'd0, 32'd0, 64'd0, 1'b0);

        // VALID pulsed mid-RUN with different operands must be ignored.
        Q = 32'd7; D = 32'd5; R = 32'd3; VALID = 1'b1;
        tick();
        VALID = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        Q = 32'd100; D = 32'd200; R = 32'd1; VALID = 1'b1;
        tick();
        VALID = 1'b0;
        wait_ready(10, cyc);
        check("midrun_latency", 64'(cyc), 64'd32);
        check("midrun_n", N, 64'd38);
        check("midrun_err", 64'(range_err), 64'd0);

        // Reset in the middle of RUN aborts everything.
        Q = 32'd9; D = 32'd9; R = 32'd20; VALID = 1'b1;
        tick();
        VALID = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_before", 64'(BUSY), 64'd1);
        reset = 1'b0;
        tick();
        check("abort_n", N, 64'd0);
        check("abort_ready", 64'(READY), 64'd0);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_err", 64'(range_err), 64'd0);
        reset = 1'b1;
        tick();
        check("abort_idle_busy", 64'(BUSY), 64'd0);
        run_op("after_abort", 32'd2, 32'd3, 32'd1, 64'd7, 1'b0);

        // VALID held high across two operations.
        Q = 32'd1; D = 32'd1; R = 32'd0; VALID = 1'b1;
        tick();
        Q = 32'd3; D = 32'd4; R = 32'd2;
        wait_ready(0, cyc);
        check("b2b_first_latency", 64'(cyc), 64'd32);
        check("b2b_first_n", N, 64'd1);
        tick();
        check("b2b_ready_drop", 64'(READY), 64'd0);
        check("b2b_busy_again", 64'(BUSY), 64'd1);
        check("b2b_n_cleared", N, 64'd0);
        wait_ready(1, cyc);
        VALID = 1'b0;
        check("b2b_second_gap", 64'(cyc), 64'd33);
        check("b2b_second_n", N, 64'd14);
        check("b2b_second_err", 64'(range_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unsigned_multiply_reconstruct.md
# unsigned_multiply_reconstruct

- Sequential unsigned shift-add multiplier computing N = Q × D + R.
- Inverse of the long-division datapath: takes a quotient, divisor and remainder and rebuilds the 2·WIDTH-bit dividend.
- Used as a round-trip checker and as the multiply path beside the divider in the arithmetic unit.
- Fixed-latency, one bit of Q per cycle; same VALID/READY handshake style as the divider.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low (0 = reset, sampled on rising clk).
- VALID  input  1  start request; sampled only when not BUSY.
- Q  input  WIDTH  multiplier (quotient); sampled on accept.
- D  input  WIDTH  multiplicand (divisor); sampled on accept.
- R  input  WIDTH  addend (remainder); sampled on accept.
- N  output  2·WIDTH  result; valid while READY=1.
- READY  output  1  level; result available, held until next accept or reset.
- BUSY  output  1  computation in progress.
- range_err  output  1  R ≥ D for the accepted operands (inconsistent remainder); valid with READY.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on VALID=1.
- RUN → DONE after exactly WIDTH iterations.
- DONE → RUN on VALID=1 (back-to-back allowed).
- DONE holds otherwise.
- Accept (IDLE or DONE with VALID=1), registered on that edge:
  - mcand ← D; mplier ← Q; acc ← {WIDTH'b0, R}; count ← 0.
  - BUSY ← 1; READY ← 0; range_err ← (R ≥ D).
- Each RUN cycle:
  - if mplier[0]: acc ← acc + (mcand << count), 2·WIDTH-bit add.
  - mplier ← mplier >> 1; count ← count + 1.
- Final iteration (count = WIDTH−1):
  - N ← updated acc; READY ← 1; BUSY ← 0; state → DONE.
- No early termination: latency is independent of operand values.
- Width rule: max result (2^W−1)² + (2^W−1) = 2^(2W) − 2^W fits in 2·WIDTH bits, so no overflow output exists. Addition is unsigned and never truncated.
- D = 0: the multiplication still runs, N = R, range_err = 1 whenever R ≠ 0.
- The D = 0, R = 0 case gives range_err = 0 (R ≥ D is true only as equality with 0). Decided: range_err = (R ≥ D) && (D ≠ 0 || R ≠ 0).
- VALID during RUN is ignored. Q/D/R changes during RUN have no effect.
- N, range_err are stable in DONE; they change only on an accepted start (cleared to 0) or at completion.

## Timing
- Reset values: N = 0, READY = 0, BUSY = 0, range_err = 0, state = IDLE, count = 0.
- Accept at edge E0: BUSY = 1, READY = 0 visible after E0.
- Iterations occur on edges E1..E_WIDTH.
- READY = 1, BUSY = 0 and N valid after edge E_WIDTH.
- Latency is WIDTH cycles from accept to READY.
- Back-to-back: VALID high in DONE at edge E_k restarts.
  - READY drops after E_k.
  - Throughput is one result per WIDTH+1 cycles with VALID held high.
- reset = 0 on any edge, including mid-RUN, aborts the operation and restores all reset values on that edge. Reset overrides VALID.
- One clock domain; no combinational path from inputs to outputs.

## Structure
- Shared package `arith_pkg`:
  - WIDTH default.
  - FSM state enum {IDLE, RUN, DONE}.
  - Count width $clog2(WIDTH).
- Sub-module `partial_product_calculator`, combinational:
  - inputs acc_in, mcand, mplier_bit, count.
  - output acc_out = acc_in + (mplier_bit ? mcand << count : 0).
  - Mirrors the per-step calculator split used by the divider.
- Top holds the FSM, counter, operand registers and output registers.

## Test plan
- Q=7, D=5, R=3, VALID one cycle → after 32 cycles READY=1, N=0x26 (38), range_err=0, BUSY=0.
- Q=D=0xFFFFFFFF, R=0xFFFFFFFE → N=0xFFFFFFFEFFFFFFFF, range_err=0; confirms no truncation at max operands.
- Q=5, D=0, R=3 → N=3, range_err=1. Q=0, D=9, R=9 → N=9, range_err=1.
- VALID pulsed again mid-RUN with new operands → ignored; original result appears at the original cycle.
- reset=0 at RUN cycle 10 → next edge all outputs 0, IDLE. Then Q=2, D=3, R=1 → N=7 after 32 cycles.
- VALID held high across two ops (Q=1, D=1, R=0, then Q=3, D=4, R=2):
  - READY high one cycle with N=1.
  - Second READY 33 cycles later with N=14.
